// File: rtl/fu_complete.sv
// Completion collector for the fixed-latency integer units: tracks issued uops,
// pairs tags with unit results, and buffers them in-order for a single writeback port.
module fu_complete #(
  parameter int TAG_W        = 6,
  parameter int PREG_W       = 6,
  parameter int IMUL_LATENCY = 5,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iss_alu_valid,
  input  logic [TAG_W-1:0]  iss_alu_tag,
  input  logic [PREG_W-1:0] iss_alu_prd,
  input  logic              iss_alu_wen,
  input  logic              iss_br_valid,
  input  logic [TAG_W-1:0]  iss_br_tag,
  input  logic              iss_mul_valid,
  input  logic [TAG_W-1:0]  iss_mul_tag,
  input  logic [PREG_W-1:0] iss_mul_prd,
  input  logic [31:0]       alu_result,
  input  logic              br_taken,
  input  logic [31:0]       mul_result,
  output logic              issue_ready,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [PREG_W-1:0] wb_prd,
  output logic              wb_wen,
  output logic [31:0]       wb_data,
  output logic              wb_is_br,
  output logic              wb_taken,
  output logic              overflow_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = PW + $clog2(IMUL_LATENCY + 3) + 1;
  localparam int L  = IMUL_LATENCY;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PREG_W-1:0] prd;
    logic              wen;
    logic [31:0]       data;
    logic              is_br;
    logic              taken;
  } wb_entry_t;

  logic                        alu_v, alu_wen, br_v;
  logic [TAG_W-1:0]            alu_tag, br_tag;
  logic [PREG_W-1:0]           alu_prd;
  logic [L-1:0]                mul_vld_pipe;
  logic [L-1:0][TAG_W-1:0]     mul_tag_pipe;
  logic [L-1:0][PREG_W-1:0]    mul_prd_pipe;

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  wb_entry_t     mem [FIFO_DEPTH];
  wb_entry_t     head;
  wb_entry_t     src_e [3];
  logic [2:0]    src_v, we;
  logic [2:0][AW-1:0] slot;
  logic [SW-1:0] free, push_cnt, inflight;
  logic          pop, drop;

  assign count    = wr_ptr - rd_ptr;
  assign wb_valid = (count != '0);
  assign pop      = wb_valid && wb_ready;
  assign free     = SW'(FIFO_DEPTH) - SW'(count) + SW'(pop);

  // Source index 0/1/2 = mul/alu/br: mul was issued earliest, so it lands first.
  assign src_v = {br_v, alu_v, mul_vld_pipe[L-1]};
  assign src_e[0] = '{tag: mul_tag_pipe[L-1], prd: mul_prd_pipe[L-1], wen: 1'b1,
                      data: mul_result, is_br: 1'b0, taken: 1'b0};
  assign src_e[1] = '{tag: alu_tag, prd: alu_prd, wen: alu_wen,
                      data: alu_result, is_br: 1'b0, taken: 1'b0};
  assign src_e[2] = '{tag: br_tag, prd: '0, wen: 1'b0,
                      data: 32'd0, is_br: 1'b1, taken: br_taken};

  always_comb begin
    push_cnt = '0;
    drop     = 1'b0;
    we       = '0;
    slot     = '0;
    for (int i = 0; i < 3; i++) begin
      if (src_v[i]) begin
        if (push_cnt < free) begin
          we[i]    = 1'b1;
          slot[i]  = wr_ptr[AW-1:0] + AW'(push_cnt);
          push_cnt = push_cnt + SW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    inflight = SW'(alu_v) + SW'(br_v);
    for (int i = 0; i < L; i++) inflight = inflight + SW'(mul_vld_pipe[i]);
  end

  // Reserve room for a worst-case 3-way issue so the non-stalling units never overflow.
  assign issue_ready = (SW'(count) + inflight + SW'(3)) <= SW'(FIFO_DEPTH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_v        <= 1'b0;
      alu_tag      <= '0;
      alu_prd      <= '0;
      alu_wen      <= 1'b0;
      br_v         <= 1'b0;
      br_tag       <= '0;
      mul_vld_pipe <= '0;
      mul_tag_pipe <= '0;
      mul_prd_pipe <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      alu_v           <= iss_alu_valid;
      alu_tag         <= iss_alu_tag;
      alu_prd         <= iss_alu_prd;
      alu_wen         <= iss_alu_wen;
      br_v            <= iss_br_valid;
      br_tag          <= iss_br_tag;
      mul_vld_pipe[0] <= iss_mul_valid;
      mul_tag_pipe[0] <= iss_mul_tag;
      mul_prd_pipe[0] <= iss_mul_prd;
      for (int i = 1; i < L; i++) begin
        mul_vld_pipe[i] <= mul_vld_pipe[i-1];
        mul_tag_pipe[i] <= mul_tag_pipe[i-1];
        mul_prd_pipe[i] <= mul_prd_pipe[i-1];
      end
      wr_ptr       <= wr_ptr + PW'(push_cnt);
      rd_ptr       <= rd_ptr + PW'(pop);
      overflow_err <= overflow_err | drop;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++)
      if (we[i]) mem[slot[i]] <= src_e[i];
  end

  assign head     = wb_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign wb_tag   = head.tag;
  assign wb_prd   = head.prd;
  assign wb_wen   = head.wen;
  assign wb_data  = head.data;
  assign wb_is_br = head.is_br;
  assign wb_taken = head.taken;
endmodule

// File: doc/fu_complete.md
# fu_complete

Completion collector at the output end of the integer function units (alu, branch, imul). It tracks every issued micro-op through its fixed-latency unit and pairs the tag with the data when that data emerges. Completed results are buffered in an in-order FIFO and presented on a single valid/ready writeback port toward the ROB/PRF. It provides issue-side backpressure so the fixed-latency units, which cannot stall, never overflow the buffer.

## Interface
- TAG_W, 6, ROB tag width
- PREG_W, 6, physical destination register width
- IMUL_LATENCY, 5, cycles from imul issue to valid `mul_result`
- FIFO_DEPTH, 8, result buffer entries; power of two, at least 4
- `clock` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `iss_alu_valid` in 1: alu uop issued this cycle
- `iss_alu_tag` in TAG_W: its ROB tag
- `iss_alu_prd` in PREG_W: its destination preg
- `iss_alu_wen` in 1: uop writes rd
- `iss_br_valid` in 1: branch uop issued this cycle
- `iss_br_tag` in TAG_W: its ROB tag
- `iss_mul_valid` in 1: imul uop issued this cycle (always writes rd)
- `iss_mul_tag` in TAG_W: its ROB tag
- `iss_mul_prd` in PREG_W: its destination preg
- `alu_result` in 32: alu output, valid 1 cycle after issue
- `br_taken` in 1: branch output, valid 1 cycle after issue
- `mul_result` in 32: imul output, valid IMUL_LATENCY cycles after issue
- `issue_ready` out 1: upstream may issue this cycle
- `wb_valid` out 1: writeback entry present
- `wb_ready` in 1: consumer accepts the entry
- `wb_tag` out TAG_W: ROB tag of the entry
- `wb_prd` out PREG_W: destination preg of the entry
- `wb_wen` out 1: entry writes the PRF
- `wb_data` out 32: result data; 0 for branches
- `wb_is_br` out 1: entry is a branch
- `wb_taken` out 1: branch outcome; 0 for non-branches
- `overflow_err` out 1: sticky, set when a push finds the FIFO full

## Operation
- Tracking pipes:
  - alu: 1-stage pipe of {valid, tag, prd, wen}.
  - br: 1-stage pipe of {valid, tag}.
  - mul: IMUL_LATENCY-stage shift pipe of {valid, tag, prd}.
- A pipe tail with valid=1 samples its data input in that cycle and pushes one FIFO entry at the clock edge.
- Up to 3 pushes per cycle, written in fixed order mul, alu, br into consecutive slots starting at the write pointer. Mul goes first because it was issued earliest.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. `count` ranges 0..FIFO_DEPTH.
- Pop occurs when `wb_valid && wb_ready`. Push and pop in the same cycle are both performed; the popped entry is the old head.
- `inflight` = number of valid stages across all three pipes.
- `issue_ready` = (count + inflight + 3 <= FIFO_DEPTH). It is combinational from registers and does not look at `wb_ready`.
- Upstream must not assert any `iss_*_valid` while `issue_ready`=0. If it does, the uop is still tracked. A resulting push into a full FIFO is dropped and sets `overflow_err`.
- wb outputs reflect the FIFO head combinationally. `wb_valid` = (count != 0).
- No flush; squashed results are written back and discarded by the ROB.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - All pipes invalid, pointers 0, `overflow_err`=0.
  - `wb_valid`=0, `issue_ready`=1, all other wb outputs 0.
- Reset mid-operation drops all in-flight and buffered entries. Unit outputs arriving after reset are ignored because the pipes are invalid.
- alu or br issued in cycle N: data in cycle N+1, push at the end of N+1, earliest `wb_valid` in cycle N+2.
- imul issued in cycle N: push at the end of N+IMUL_LATENCY, earliest `wb_valid` in cycle N+IMUL_LATENCY+1.
- With `wb_ready` held high and no contention, the writeback order equals push order. Each entry is on the port for exactly 1 cycle.
- A full FIFO with `wb_ready`=1 and a simultaneous push: the pop frees a slot first, so one push succeeds.
- Wrap-around: after 2·FIFO_DEPTH pushes, pointers return to 0. Full/empty are distinguished by the pointer MSB.

## Test plan
- Reset, then alu issue tag=3 prd=5 wen=1 with `alu_result`=0x1234 next cycle → `wb_valid` 2 cycles after issue, carrying {3, 5, 1, 0x1234, is_br=0}.
- imul issue tag=7 at cycle 0, alu issue tag=8 at cycle 4 → both push at the end of cycle 5 → wb shows tag 7 in cycle 6 and tag 8 in cycle 7.
- Branch tag=2 with `br_taken`=1 → wb {tag=2, wen=0, data=0, is_br=1, taken=1}.
- `wb_ready`=0, issue alu every cycle while `issue_ready`=1 → `issue_ready` falls when count+inflight reaches 6. `overflow_err` stays 0 and exactly 6 entries drain in order once `wb_ready`=1.
- Stream 40 alu ops with `wb_ready` toggling 1/0 → all 40 tags are written back in order with no loss across pointer wrap.
- Assert `reset_n`=0 with 3 entries buffered and 2 imuls in flight → `wb_valid`=0 immediately. No writeback occurs after release, and `issue_ready`=1.
